// File: rtl/disparity_pkg.sv
// Shared types and width helpers for the disparity normalizer and its divider.
// Pure declarations: no latency, no flow control.
package disparity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } div_state_t;

    function automatic int num_width(input int disp_bits, input int group_size);
        return 8 + disp_bits + $clog2(group_size);
    endfunction

    function automatic int den_width(input int group_size);
        return 8 + $clog2(group_size);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first; done asserts quot_bits+1 cycles after start.
// No backpressure: start is honoured in IDLE or DONE and ignored while busy.
module seq_divider
    import disparity_pkg::*;
#(
    parameter int dividend_bits = 16,
    parameter int divisor_bits  = 11,
    parameter int quot_bits     = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [dividend_bits-1:0] dividend,
    input  logic [divisor_bits-1:0]  divisor,
    output logic                     busy,
    output logic                     done,
    output logic [quot_bits-1:0]     quotient
);

    localparam int RW = dividend_bits;
    localparam int SW = dividend_bits + 1;
    localparam int IW = $clog2(quot_bits + 1);

    div_state_t state, state_nxt;

    logic [RW-1:0]        rem;
    logic [quot_bits-1:0] dvd_lo;
    logic [divisor_bits-1:0] dvs;
    logic [quot_bits-1:0] quot;
    logic [IW-1:0]        iter;
    logic                 sat;
    logic                 zero;

    logic [SW-1:0] shifted;
    logic          fits;
    logic          accept;

    assign shifted = {rem, dvd_lo[quot_bits-1]};
    assign fits    = shifted >= SW'(dvs);
    assign accept  = start && (state != DIV);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (iter == IW'(quot_bits - 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? DIV : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // The upper dividend bits seed the remainder; if they already reach the
    // divisor the quotient cannot fit in quot_bits and is saturated.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem    <= '0;
            dvd_lo <= '0;
            dvs    <= '0;
            quot   <= '0;
            iter   <= '0;
            sat    <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            rem    <= dividend >> quot_bits;
            dvd_lo <= dividend[quot_bits-1:0];
            dvs    <= divisor;
            quot   <= '0;
            iter   <= '0;
            zero   <= (divisor == '0);
            sat    <= (dividend >> quot_bits) >= RW'(divisor);
        end else if (state == DIV) begin
            iter   <= iter + IW'(1);
            dvd_lo <= dvd_lo << 1;
            if (!zero) begin
                rem  <= fits ? RW'(shifted - SW'(dvs)) : RW'(shifted);
                quot <= (quot << 1) | quot_bits'(fits);
            end
        end
    end

    assign quotient = zero ? '0 : (sat ? '1 : quot);

endmodule

// File: rtl/disparity_normalizer.sv
// Group-averages weighted disparity: disp_out = sum(disp*conf)/sum(conf), out_valid disp_bits+1 cycles after the completing sample.
// No backpressure: a group finishing while the divider is busy is dropped and flags overrun.
module disparity_normalizer
    import disparity_pkg::*;
#(
    parameter int disp_bits        = 5,
    parameter int group_size       = 8,
    parameter bit check_group_size = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8+disp_bits-1:0] disp_conf_in,
    input  logic [7:0]             conf_in,
    input  logic                   in_valid,
    input  logic                   line_start,
    output logic [disp_bits-1:0]   disp_out,
    output logic [7:0]             conf_out,
    output logic                   out_valid,
    output logic                   overrun
);

    localparam int CW = $clog2(group_size);
    localparam int NW = num_width(disp_bits, group_size);
    localparam int DW = den_width(group_size);

    // Groups must arrive no faster than the divider can drain them.
    if (check_group_size &&
        ((group_size < disp_bits + 2) || ((1 << CW) != group_size))) begin : g_bad_group
        $error("disparity_normalizer: group_size must be a power of 2 and >= disp_bits+2");
    end

    logic [NW-1:0]        num_acc;
    logic [DW-1:0]        den_acc;
    logic [CW-1:0]        count;
    logic [7:0]           conf_hold;

    logic [NW-1:0]        num_next;
    logic [DW-1:0]        den_next;
    logic                 complete;
    logic                 start;
    logic                 div_busy;
    logic                 div_done;
    logic [disp_bits-1:0] quotient;

    assign num_next = num_acc + NW'(disp_conf_in);
    assign den_next = den_acc + DW'(conf_in);
    assign complete = in_valid && !line_start && (count == CW'(group_size - 1));
    assign start    = complete && !div_busy;

    seq_divider #(
        .dividend_bits (NW),
        .divisor_bits  (DW),
        .quot_bits     (disp_bits)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (num_next),
        .divisor  (den_next),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_acc   <= '0;
            den_acc   <= '0;
            count     <= '0;
            conf_hold <= '0;
            disp_out  <= '0;
            conf_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (line_start || complete) begin
                num_acc <= '0;
                den_acc <= '0;
                count   <= '0;
            end else if (in_valid) begin
                num_acc <= num_next;
                den_acc <= den_next;
                count   <= count + CW'(1);
            end
            // Mean confidence is captured with the dividend so back-to-back groups stay paired.
            if (start) conf_hold <= den_next[DW-1:CW];
            if (complete && div_busy) overrun <= 1'b1;
            out_valid <= div_done;
            if (div_done) begin
                disp_out <= quotient;
                conf_out <= conf_hold;
            end
        end
    end

endmodule

// File: tb/tb_disparity_normalizer.sv
// Directed-vector bench for disparity_normalizer; a second instance with group_size=4 exercises overrun.
module tb_disparity_normalizer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reset2_n = 1'b0;
    logic [12:0] disp_conf_in = '0;
    logic [7:0]  conf_in = '0;
    logic        in_valid = 1'b0;
    logic        line_start = 1'b0;
    logic [4:0]  disp_out, disp_out2;
    logic [7:0]  conf_out, conf_out2;
    logic        out_valid, out_valid2;
    logic        overrun, overrun2;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int pcyc[$];
    int pdisp[$];
    int pconf[$];

    always #5 clk = ~clk;

    disparity_normalizer #(.disp_bits(5), .group_size(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .disp_conf_in (disp_conf_in),
        .conf_in      (conf_in),
        .in_valid     (in_valid),
        .line_start   (line_start),
        .disp_out     (disp_out),
        .conf_out     (conf_out),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    disparity_normalizer #(.disp_bits(5), .group_size(4), .check_group_size(1'b0)) dut_small (
        .clk          (clk),
        .reset_n      (reset2_n),
        .disp_conf_in (disp_conf_in),
        .conf_in      (conf_in),
        .in_valid     (in_valid),
        .line_start   (line_start),
        .disp_out     (disp_out2),
        .conf_out     (conf_out2),
        .out_valid    (out_valid2),
        .overrun      (overrun2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            pcyc.push_back(cyc);
            pdisp.push_back(int'(disp_out));
            pconf.push_back(int'(conf_out));
        end
    endtask

    task automatic drive(input int dc, input int c, input bit v, input bit ls);
        disp_conf_in = 13'(dc);
        conf_in      = 8'(c);
        in_valid     = v;
        line_start   = ls;
        tick();
    endtask

    task automatic idle(input int n);
        disp_conf_in = '0;
        conf_in      = '0;
        in_valid     = 1'b0;
        line_start   = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        pcyc.delete();
        pdisp.delete();
        pconf.delete();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        reset2_n = 1'b0;
        idle(3);
        checks++; if (disp_out !== 5'd0) $display("FAIL reset_disp: got %0d want 0", disp_out); else passed++;
        checks++; if (conf_out !== 8'd0) $display("FAIL reset_conf: got %0d want 0", conf_out); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
        checks++; if (overrun2 !== 1'b0) $display("FAIL reset_overrun_small: got %b want 0", overrun2); else passed++;
        reset_n  = 1'b1;
        reset2_n = 1'b1;
        idle(1);
    endtask

    task automatic test_weighted_mean();
        int dca[5]  = '{200, 1953, 30, 0, 8191};
        int ca[5]   = '{20,  63,   10, 0, 1};
        int dcb[5]  = '{200, 0,    40, 0, 8191};
        int cb[5]   = '{20,  0,    10, 0, 1};
        int exp_d[5] = '{10, 31, 3, 0, 31};
        int exp_c[5] = '{20, 31, 10, 0, 1};
        int e0;
        for (int v = 0; v < 5; v++) begin
            clear_log();
            for (int i = 0; i < 4; i++) drive(dca[v], ca[v], 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) drive(dcb[v], cb[v], 1'b1, 1'b0);
            e0 = cyc;
            idle(10);
            checks++;
            if (pcyc.size() !== 1) $display("FAIL mean%0d_pulses: got %0d want 1", v, pcyc.size());
            else passed++;
            if (pcyc.size() >= 1) begin
                checks++;
                if (pcyc[0] !== e0 + 6) $display("FAIL mean%0d_latency: got %0d want %0d", v, pcyc[0] - e0, 6);
                else passed++;
                checks++;
                if (pdisp[0] !== exp_d[v]) $display("FAIL mean%0d_disp: got %0d want %0d", v, pdisp[0], exp_d[v]);
                else passed++;
                checks++;
                if (pconf[0] !== exp_c[v]) $display("FAIL mean%0d_conf: got %0d want %0d", v, pconf[0], exp_c[v]);
                else passed++;
            end
        end
        checks++;
        if (disp_out !== 5'd31) $display("FAIL hold_disp: got %0d want 31", disp_out); else passed++;
    endtask

    task automatic test_line_start();
        int e0;
        clear_log();
        for (int i = 0; i < 3; i++) drive(200, 20, 1'b1, 1'b0);
        drive(8191, 255, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive(200, 20, 1'b1, 1'b0);
        e0 = cyc;
        drive(0, 0, 1'b0, 1'b1);
        idle(10);
        checks++;
        if (pcyc.size() !== 1) $display("FAIL line_start_pulses: got %0d want 1", pcyc.size()); else passed++;
        if (pcyc.size() >= 1) begin
            checks++;
            if (pcyc[0] !== e0 + 6) $display("FAIL line_start_latency: got %0d want 6", pcyc[0] - e0); else passed++;
            checks++;
            if (pdisp[0] !== 10) $display("FAIL line_start_disp: got %0d want 10", pdisp[0]); else passed++;
            checks++;
            if (pconf[0] !== 20) $display("FAIL line_start_conf: got %0d want 20", pconf[0]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int dcs[3]   = '{50, 170, 310};
        int exp_d[3] = '{5, 17, 31};
        int e0 = 0;
        clear_log();
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 8; i++) drive(dcs[g], 10, 1'b1, 1'b0);
            if (g == 0) e0 = cyc;
        end
        idle(12);
        checks++;
        if (pcyc.size() !== 3) $display("FAIL b2b_pulses: got %0d want 3", pcyc.size()); else passed++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else passed++;
        for (int k = 0; k < 3; k++) begin
            if (k < pcyc.size()) begin
                checks++;
                if (pcyc[k] !== e0 + 6 + 8 * k)
                    $display("FAIL b2b_time%0d: got %0d want %0d", k, pcyc[k] - e0, 6 + 8 * k);
                else passed++;
                checks++;
                if (pdisp[k] !== exp_d[k]) $display("FAIL b2b_disp%0d: got %0d want %0d", k, pdisp[k], exp_d[k]);
                else passed++;
                checks++;
                if (pconf[k] !== 10) $display("FAIL b2b_conf%0d: got %0d want 10", k, pconf[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int e0;
        clear_log();
        for (int i = 0; i < 8; i++) drive(200, 20, 1'b1, 1'b0);
        idle(2);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(10);
        checks++;
        if (pcyc.size() !== 0) $display("FAIL rst_div_pulses: got %0d want 0", pcyc.size()); else passed++;
        checks++;
        if (disp_out !== 5'd0) $display("FAIL rst_div_disp: got %0d want 0", disp_out); else passed++;
        checks++;
        if (conf_out !== 8'd0) $display("FAIL rst_div_conf: got %0d want 0", conf_out); else passed++;
        clear_log();
        for (int i = 0; i < 8; i++) drive(300, 10, 1'b1, 1'b0);
        e0 = cyc;
        idle(10);
        checks++;
        if (pcyc.size() !== 1) $display("FAIL rst_fresh_pulses: got %0d want 1", pcyc.size()); else passed++;
        if (pcyc.size() >= 1) begin
            checks++;
            if (pcyc[0] !== e0 + 6) $display("FAIL rst_fresh_latency: got %0d want 6", pcyc[0] - e0); else passed++;
            checks++;
            if (pdisp[0] !== 30) $display("FAIL rst_fresh_disp: got %0d want 30", pdisp[0]); else passed++;
            checks++;
            if (pconf[0] !== 10) $display("FAIL rst_fresh_conf: got %0d want 10", pconf[0]); else passed++;
        end
    endtask

    task automatic test_overrun();
        reset2_n = 1'b0;
        idle(1);
        checks++;
        if (overrun2 !== 1'b0) $display("FAIL ovr_initial: got %b want 0", overrun2); else passed++;
        reset2_n = 1'b1;
        for (int i = 0; i < 12; i++) drive(200, 20, 1'b1, 1'b0);
        idle(20);
        checks++;
        if (overrun2 !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun2); else passed++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL ovr_main_clear: got %b want 0", overrun); else passed++;
        reset2_n = 1'b0;
        idle(1);
        checks++;
        if (overrun2 !== 1'b0) $display("FAIL ovr_reset: got %b want 0", overrun2); else passed++;
        reset2_n = 1'b1;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_weighted_mean();
        test_line_start();
        test_back_to_back();
        test_reset_mid_div();
        test_overrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/disparity_normalizer.md
Name: disparity_normalizer

Overview:
Downstream consumer of the per-pixel weighted disparity stream (disp*conf product plus conf) produced by the disparity filtering pixel stage. Accumulates a fixed group of consecutive valid samples and recovers the confidence-weighted mean disparity, sum(disp*conf)/sum(conf), using a multi-cycle restoring divider. It also outputs the group's mean confidence. Sits between the pixel stage and the filtered-disparity writer.

Parameters:
disp_bits, 5, width of disparity values (input product width is 8+disp_bits)
group_size, 8, samples per averaging group; power of 2; must be >= disp_bits+2 (enforced by elaboration assertion)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
disp_conf_in  in  8+disp_bits  disp*conf product for one sample
conf_in  in  8  confidence for the same sample
in_valid  in  1  sample strobe; no backpressure, may be high every cycle
line_start  in  1  discard any partial group; takes priority over in_valid in the same cycle
disp_out  out  disp_bits  weighted mean disparity, truncated
conf_out  out  8  sum(conf) >> log2(group_size)
out_valid  out  1  single-cycle result strobe
overrun  out  1  sticky error flag; cleared only by reset

Behaviour:
- One clock domain. Synchronous active-low reset: reset_n is sampled on the rising edge of clk.
- Reset state: all accumulators, counters and output registers are 0. out_valid=0, overrun=0, FSM in IDLE. Reset mid-division aborts the division, and no out_valid is produced for that group.
- Accumulators: num_acc is 8+disp_bits+log2(group_size) bits; den_acc is 8+log2(group_size) bits. Sample counter is log2(group_size) bits. Overflow is impossible by construction.
- Accumulation: on each in_valid edge with line_start=0, add both inputs to the accumulators and increment the counter.
- Group completion: happens on the edge where in_valid=1 and count==group_size-1. At that edge:
  - num_acc+disp_conf_in and den_acc+conf_in are loaded into the divider.
  - Accumulators and counter clear to 0.
- line_start=1: accumulators and counter clear and the current sample is dropped. An in-progress division is unaffected.
- FSM states:
  - IDLE: on group completion, load the divider and go to DIV.
  - DIV: runs disp_bits restoring iterations, one quotient bit per cycle, MSB first, using remainder = (remainder<<1 | next num bit) - den. After the last iteration, go to DONE.
  - DONE: register disp_out, conf_out and out_valid=1 for exactly one cycle, then go to IDLE. A group completing in DONE is accepted: load the divider and go to DIV.
- Latency: out_valid asserts on edge E0+disp_bits+1, where E0 is the completing edge.
- den==0: skip the iterations; disp_out=0, conf_out=0. out_valid still pulses at the same latency.
- Quotient: guaranteed < 2^disp_bits because every per-sample disp is < 2^disp_bits. If the result would exceed the range anyway, it saturates to all-ones.
- Overrun: a group completing while in DIV sets overrun=1. That group is discarded and the division in progress continues unaffected.
- disp_out and conf_out hold their values between strobes.

Decomposition:
- Shared package disparity_pkg:
  - FSM state enum (IDLE, DIV, DONE)
  - width helper functions: num_width(disp_bits, group_size), den_width(group_size)
- Sub-module seq_divider: a restoring unsigned divider with start/busy/done outputs and parameterised dividend, divisor and quotient widths. The FSM lives in seq_divider; the top level holds the accumulators and output registers.

Test Plan:
- 8 samples, disp=10, conf=20 (disp_conf=200), in_valid continuous -> single out_valid 6 cycles after the 8th sample; disp_out=10, conf_out=20.
- 4 samples (1953, 63) followed by 4 samples (0, 0) -> disp_out=31 (7812/252), conf_out=31.
- 4x(30, 10) followed by 4x(40, 10) -> 280/80 truncates to disp_out=3, conf_out=10.
- 8 samples of (0, 0) -> out_valid pulses; disp_out=0, conf_out=0.
- 3 samples, then line_start, then 8 samples of (200, 20) -> exactly one out_valid with disp_out=10. Also drive line_start with in_valid in the same cycle and check that sample is dropped.
- 24 samples continuous -> three out_valid pulses spaced 8 cycles apart, overrun=0.
- reset_n low during DIV -> no out_valid and all outputs 0. After release, a fresh group produces a correct result.
- Test build with group_size forced to 4 (assertion disabled) and continuous input -> overrun=1 and stays set until reset.
